// File: rtl/channel_readout.sv
// channel_readout
//   Reads one event from a sampling channel and frames it for a 16-bit
//   valid/ready stream. The frame is a header word, N sample words and a
//   trailer word. All words go through a small show-ahead FIFO. The FIFO
//   holds more words than any event can produce, so writes never stall.
//
// Ports
//   CLK, RESET_N    clock; asynchronous active-low reset
//   start           one-cycle request to read out an event (IDLE only)
//   howmany_cfg     sample count N to latch on an accepted start
//   offset_cfg      pre-trigger offset to latch on an accepted start
//   rd_request      one-cycle readout request to the channel
//   howmany, offset latched N and offset, driven to the channel
//   din             channel sample stream, one sample per cycle
//   m_data, m_valid output word stream (FIFO head / FIFO non-empty)
//   m_ready         downstream accepts the word
//   busy            an event is in progress
//   done            one-cycle pulse when the event has fully drained
module channel_readout #(
  parameter int         SIZE    = 8,
  parameter int         WIDTH   = 12,
  parameter int         RD_LAT  = 2,
  parameter logic [3:0] CHAN_ID = 4'h0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [SIZE-1:0]  howmany_cfg,
  input  logic [SIZE-1:0]  offset_cfg,
  output logic             rd_request,
  output logic [SIZE-1:0]  howmany,
  output logic [SIZE-1:0]  offset,
  input  logic [WIDTH-1:0] din,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done
);

  localparam int AW    = SIZE + 1;
  localparam int DEPTH = 1 << AW;

  // Index of the last WAIT cycle. With RD_LAT=1 the WAIT state is skipped
  // entirely, so the value is irrelevant in that case.
  localparam logic [3:0]      WAIT_LAST = (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [SIZE-1:0] CNT_ONE   = 1;
  localparam logic [AW-1:0]   PTR_ONE   = 1;
  localparam logic [AW:0]     OCC_ONE   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_COLLECT,
    S_TRL,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] howmany_q, howmany_d;
  logic [SIZE-1:0] offset_q, offset_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;

  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;

  logic            wr_en;
  logic [15:0]     wr_data;
  logic            rd_en;

  // Event sequencing: decides the next state and which word (if any) is
  // pushed into the FIFO this cycle.
  always_comb begin
    state_d    = state_q;
    howmany_d  = howmany_q;
    offset_d   = offset_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    wr_en      = 1'b0;
    wr_data    = 16'h0000;
    rd_request = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          howmany_d  = howmany_cfg;
          offset_d   = offset_cfg;
          cnt_d      = '0;
          wait_cnt_d = 4'd0;
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        wr_en   = 1'b1;
        wr_data = {4'hA, CHAN_ID, 8'(howmany_q)};
        if (howmany_q != '0) begin
          rd_request = 1'b1;
          // The first sample arrives RD_LAT cycles after the request.
          state_d    = (RD_LAT == 1) ? S_COLLECT : S_WAIT;
        end else begin
          state_d = S_TRL;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_COLLECT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_COLLECT: begin
        wr_en   = 1'b1;
        wr_data = {4'h0, 12'(din)};
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_d == howmany_q) begin
          state_d = S_TRL;
        end
      end
      S_TRL: begin
        wr_en   = 1'b1;
        wr_data = {4'hE, 4'h0, 8'(cnt_q)};
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (occ_q == '0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping. A push and a pop in the same cycle cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Control and FIFO pointer registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      howmany_q  <= '0;
      offset_q   <= '0;
      cnt_q      <= '0;
      wait_cnt_q <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      howmany_q  <= howmany_d;
      offset_q   <= offset_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // FIFO storage needs no reset. Stale entries are never visible because
  // m_data is gated by m_valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign m_valid = (occ_q != '0);
  assign m_data  = m_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign rd_en   = m_valid & m_ready;
  assign busy    = (state_q != S_IDLE);
  assign howmany = howmany_q;
  assign offset  = offset_q;

endmodule
